// File: rtl/xorshift_share_ctrl.sv
// Shares one 8-bit xorshift PRNG (<<3, >>5, <<4) among N_REQ requesters.
// Handles seeding, zero-seed guard, warm-up, and round-robin arbitration with one draw per grant.
module xorshift_share_ctrl #(
  parameter int         N_REQ        = 4,
  parameter int         WARMUP_STEPS = 8,
  parameter logic [7:0] RESET_SEED   = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             seed_load_i,
  input  logic [7:0]       seed_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [7:0]       rnd_o,
  output logic             busy_o
);

  localparam int             PTR_W    = $clog2(N_REQ);
  localparam logic [7:0]     WARM_CNT = 8'(WARMUP_STEPS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  typedef enum logic {WARMUP, READY} fsm_t;

  localparam fsm_t LOAD_FSM = (WARMUP_STEPS > 0) ? WARMUP : READY;

  fsm_t             r_fsm;
  logic [7:0]       r_state;
  logic [7:0]       r_cnt;
  logic [PTR_W-1:0] r_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [7:0]       r_rnd;

  logic             w_found;
  logic [PTR_W-1:0] w_winner;
  logic [PTR_W-1:0] w_idx;

  function automatic logic [7:0] xs_step(input logic [7:0] s);
    logic [7:0] a;
    logic [7:0] b;
    a = s ^ (s << 3);
    b = a ^ (a >> 5);
    return b ^ (b << 4);
  endfunction

  function automatic logic [7:0] seed_guard(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  // Walk from the farthest candidate back to ptr+1 so the nearest requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % N_REQ);
      if (req_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm   <= LOAD_FSM;
      r_state <= seed_guard(RESET_SEED);
      r_cnt   <= WARM_CNT;
      r_ptr   <= LAST_IDX;
      r_gnt   <= '0;
      r_rnd   <= 8'h00;
    end else if (seed_load_i) begin
      r_fsm   <= LOAD_FSM;
      r_state <= seed_guard(seed_i);
      r_cnt   <= WARM_CNT;
      r_gnt   <= '0;
    end else begin
      case (r_fsm)
        WARMUP: begin
          r_state <= xs_step(r_state);
          r_cnt   <= r_cnt - 8'd1;
          r_gnt   <= '0;
          if (r_cnt <= 8'd1) r_fsm <= READY;
        end
        READY: begin
          if (en_i && w_found) begin
            r_gnt   <= N_REQ'(1) << w_winner;
            r_rnd   <= r_state;
            r_state <= xs_step(r_state);
            r_ptr   <= w_winner;
          end else begin
            r_gnt <= '0;
          end
        end
        default: r_fsm <= READY;
      endcase
    end
  end

  assign gnt_o  = r_gnt;
  assign rnd_o  = r_rnd;
  assign busy_o = (r_fsm == WARMUP);

endmodule
